// File: rtl/pcpi_issue_ctrl.sv
// PCPI initiator: issues one decoded instruction to the coprocessor bus
// and returns its result, or an error when nobody claims it in time.
//
// Ports:
//   clk, resetn                        clock, async active-low reset
//   req_valid/req_ready                instruction offer from the core
//   req_insn/req_rs1/req_rs2           instruction word and operands
//   rsp_valid/rsp_ready                response handshake back to the core
//   rsp_wr/rsp_rd/rsp_err              write flag, result, illegal-insn error
//   pcpi_valid/insn/rs1/rs2            registered request to the responders
//   pcpi_wr/rd/wait/ready              responder claim and result
module pcpi_issue_ctrl #(
    parameter int TIMEOUT  = 16,
    parameter int WATCHDOG = 0,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_err,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WD_LAST =
        CNT_W'((WATCHDOG > 0) ? WATCHDOG - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
            rsp_valid  <= 1'b0;
            rsp_wr     <= 1'b0;
            rsp_rd     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        pcpi_insn  <= req_insn;
                        pcpi_rs1   <= req_rs1;
                        pcpi_rs2   <= req_rs2;
                        pcpi_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE, BUSY: begin
                    // ready beats wait, timeout and watchdog
                    if (pcpi_ready) begin
                        rsp_wr     <= pcpi_wr;
                        rsp_rd     <= pcpi_wr ? pcpi_rd : 32'h0;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        pcpi_valid <= 1'b0;
                        state      <= RESP;
                    end else if (state == ISSUE && pcpi_wait) begin
                        cnt   <= '0;
                        state <= BUSY;
                    end else if ((state == ISSUE && cnt == TO_LAST) ||
                                 (state == BUSY && WATCHDOG != 0 &&
                                  cnt == WD_LAST)) begin
                        rsp_wr     <= 1'b0;
                        rsp_rd     <= 32'h0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        pcpi_valid <= 1'b0;
                        state      <= RESP;
                    end else if (cnt != CNT_MAX) begin
                        // with no watchdog, BUSY may last forever;
                        // hold the counter instead of wrapping
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_wr    <= 1'b0;
                        rsp_rd    <= 32'h0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Bench for pcpi_issue_ctrl: two instances (no watchdog / watchdog 8)
// driven by directed and random transactions against a timing model.
module tb_pcpi_issue_ctrl;

    localparam int TIMEOUT = 16;
    localparam int WD1     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_insn  [2];
    logic [31:0] req_rs1   [2];
    logic [31:0] req_rs2   [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic        rsp_wr    [2];
    logic [31:0] rsp_rd    [2];
    logic        rsp_err   [2];
    logic        pcpi_valid[2];
    logic [31:0] pcpi_insn [2];
    logic [31:0] pcpi_rs1  [2];
    logic [31:0] pcpi_rs2  [2];
    logic        pcpi_wr   [2];
    logic [31:0] pcpi_rd   [2];
    logic        pcpi_wait [2];
    logic        pcpi_ready[2];

    pcpi_issue_ctrl #(.TIMEOUT(TIMEOUT), .WATCHDOG(0), .CNT_W(8)) u0 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_insn(req_insn[0]), .req_rs1(req_rs1[0]),
        .req_rs2(req_rs2[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_wr(rsp_wr[0]), .rsp_rd(rsp_rd[0]), .rsp_err(rsp_err[0]),
        .pcpi_valid(pcpi_valid[0]), .pcpi_insn(pcpi_insn[0]),
        .pcpi_rs1(pcpi_rs1[0]), .pcpi_rs2(pcpi_rs2[0]),
        .pcpi_wr(pcpi_wr[0]), .pcpi_rd(pcpi_rd[0]),
        .pcpi_wait(pcpi_wait[0]), .pcpi_ready(pcpi_ready[0])
    );

    pcpi_issue_ctrl #(.TIMEOUT(TIMEOUT), .WATCHDOG(WD1), .CNT_W(8)) u1 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_insn(req_insn[1]), .req_rs1(req_rs1[1]),
        .req_rs2(req_rs2[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_wr(rsp_wr[1]), .rsp_rd(rsp_rd[1]), .rsp_err(rsp_err[1]),
        .pcpi_valid(pcpi_valid[1]), .pcpi_insn(pcpi_insn[1]),
        .pcpi_rs1(pcpi_rs1[1]), .pcpi_rs2(pcpi_rs2[1]),
        .pcpi_wr(pcpi_wr[1]), .pcpi_rd(pcpi_rd[1]),
        .pcpi_wait(pcpi_wait[1]), .pcpi_ready(pcpi_ready[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in(input int k);
        req_valid[k]  = 1'b0;
        req_insn[k]   = '0;
        req_rs1[k]    = '0;
        req_rs2[k]    = '0;
        rsp_ready[k]  = 1'b0;
        pcpi_wr[k]    = 1'b0;
        pcpi_rd[k]    = '0;
        pcpi_wait[k]  = 1'b0;
        pcpi_ready[k] = 1'b0;
    endtask

    // Outcome from the rules: cycle index 0 is the first cycle with
    // pcpi_valid high; w = first cycle wait is seen, r = ready cycle
    // (-1 = never). n = cycles pcpi_valid stays high.
    function automatic void ref_model(input int wd, input int w,
                                      input int r, output int n,
                                      output bit err);
        if (r >= 0 && r < TIMEOUT && (w < 0 || r <= w)) begin
            n = r + 1; err = 1'b0;
        end else if (w >= 0 && w < TIMEOUT) begin
            if (wd != 0 && (r < 0 || r > w + wd)) begin
                n = w + wd + 1; err = 1'b1;
            end else begin
                n = r + 1; err = 1'b0;
            end
        end else begin
            n = TIMEOUT; err = 1'b1;
        end
    endfunction

    task automatic txn(input int k, input logic [31:0] insn,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input int w, input int r, input logic wr,
                       input logic [31:0] rd, input int bp);
        int          n;
        bit          err;
        int          g;
        logic        e_wr;
        logic [31:0] e_rd;
        ref_model((k == 1) ? WD1 : 0, w, r, n, err);
        e_wr = err ? 1'b0 : wr;
        e_rd = (err || !wr) ? 32'h0 : rd;
        g = 0;
        while (!req_ready[k] && g < 50) begin
            step;
            g++;
        end
        chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_insn[k]  = insn;
        req_rs1[k]   = rs1;
        req_rs2[k]   = rs2;
        step;
        req_valid[k] = 1'b0;
        req_insn[k]  = $urandom;
        req_rs1[k]   = $urandom;
        req_rs2[k]   = $urandom;
        for (int t = 0; t < n; t++) begin
            chk("pcpi_valid_hi", 32'(pcpi_valid[k]), 32'd1);
            chk("pcpi_insn", pcpi_insn[k], insn);
            chk("pcpi_rs1", pcpi_rs1[k], rs1);
            chk("pcpi_rs2", pcpi_rs2[k], rs2);
            chk("req_ready_busy", 32'(req_ready[k]), 32'd0);
            chk("rsp_valid_early", 32'(rsp_valid[k]), 32'd0);
            pcpi_wait[k]  = (w >= 0 && t >= w);
            pcpi_ready[k] = (t == r);
            pcpi_wr[k]    = (t == r) ? wr : 1'($urandom);
            pcpi_rd[k]    = (t == r) ? rd : $urandom;
            step;
        end
        for (int b = 0; b <= bp; b++) begin
            chk("rsp_valid", 32'(rsp_valid[k]), 32'd1);
            chk("rsp_wr", 32'(rsp_wr[k]), 32'(e_wr));
            chk("rsp_rd", rsp_rd[k], e_rd);
            chk("rsp_err", 32'(rsp_err[k]), 32'(err));
            chk("pcpi_valid_lo", 32'(pcpi_valid[k]), 32'd0);
            chk("req_ready_resp", 32'(req_ready[k]), 32'd0);
            if (b == bp) begin
                clr_in(k);
                rsp_ready[k] = 1'b1;
            end else begin
                // responder noise and a second offer, both ignored
                pcpi_ready[k] = 1'($urandom);
                pcpi_wait[k]  = 1'($urandom);
                pcpi_wr[k]    = 1'b1;
                pcpi_rd[k]    = $urandom;
                req_valid[k]  = 1'($urandom);
                req_insn[k]   = $urandom;
                rsp_ready[k]  = 1'b0;
            end
            step;
        end
        clr_in(k);
        chk("rsp_valid_drop", 32'(rsp_valid[k]), 32'd0);
        chk("req_ready_back", 32'(req_ready[k]), 32'd1);
        chk("pcpi_valid_gap", 32'(pcpi_valid[k]), 32'd0);
    endtask

    task automatic rnd_txn(input int k);
        int w;
        int r;
        w = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
        if (w >= 0 && w < TIMEOUT)
            r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w))
                                            : w + int'($urandom_range(0, 40));
        else
            r = ($urandom_range(0, 2) == 0) ? -1
                                            : int'($urandom_range(0, 25));
        txn(k, $urandom, $urandom, $urandom, w, r, 1'($urandom),
            $urandom, int'($urandom_range(0, 5)));
    endtask

    initial begin
        clr_in(0);
        clr_in(1);
        resetn = 1'b0;
        #12;
        chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_pcpi_valid", 32'(pcpi_valid[0]), 32'd0);
        chk("rst_pcpi_insn", pcpi_insn[0], 32'd0);
        chk("rst_rsp_rd", rsp_rd[0], 32'd0);
        chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
        step;
        resetn = 1'b1;
        step;

        // DIVU claimed with wait, result after a long busy phase
        txn(0, 32'h0220D0B3, 32'd100, 32'd7, 2, 36, 1'b1, 32'd14, 0);
        // nobody home: timeout error after exactly TIMEOUT cycles
        txn(0, 32'h0000000B, 32'd1, 32'd2, -1, -1, 1'b0, 32'h0, 1);
        // immediate ready on the first valid cycle
        txn(0, 32'h02208033, 32'd3, 32'd4, -1, 0, 1'b1, 32'hDEADBEEF, 0);
        // ready without write flag returns zero
        txn(0, 32'h02209033, 32'd5, 32'd6, -1, 3, 1'b0, 32'h12345678, 0);
        // ready at the last timeout cycle still wins
        txn(0, 32'h0220A033, 32'd7, 32'd8, -1, 15, 1'b1, 32'hCAFE0001, 0);
        // wait on the last timeout cycle claims the insn
        txn(0, 32'h0220B033, 32'd9, 32'd1, 15, 20, 1'b1, 32'hCAFE0002, 0);
        // no watchdog: 200-cycle busy phase succeeds
        txn(0, 32'h0220C033, 32'd2, 32'd3, 2, 200, 1'b1, 32'h00000BAD, 0);
        // backpressure 5 cycles
        txn(0, 32'h0220E033, 32'd4, 32'd5, 1, 4, 1'b1, 32'h55AA55AA, 5);
        // watchdog instance: wait held, no ready
        txn(1, 32'h0220F033, 32'd6, 32'd7, 2, -1, 1'b1, 32'h0, 0);
        // watchdog instance: ready on the last busy cycle
        txn(1, 32'h0220D033, 32'd8, 32'd9, 0, 8, 1'b1, 32'hA5A5A5A5, 0);

        for (int i = 0; i < 40; i++) rnd_txn(0);
        for (int i = 0; i < 25; i++) rnd_txn(1);

        // reset while busy
        req_valid[0] = 1'b1;
        req_insn[0]  = 32'h0220D0B3;
        step;
        req_valid[0] = 1'b0;
        pcpi_wait[0] = 1'b1;
        for (int i = 0; i < 5; i++) step;
        chk("busy_before_rst", 32'(pcpi_valid[0]), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_pcpi_valid", 32'(pcpi_valid[0]), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("arst_req_ready", 32'(req_ready[0]), 32'd1);
        step;
        resetn = 1'b1;
        pcpi_wait[0]  = 1'b0;
        pcpi_ready[0] = 1'b1;
        pcpi_wr[0]    = 1'b1;
        pcpi_rd[0]    = 32'h0000000E;
        step;
        clr_in(0);
        chk("late_rdy_rsp", 32'(rsp_valid[0]), 32'd0);
        chk("late_rdy_pcpi", 32'(pcpi_valid[0]), 32'd0);
        chk("late_rdy_req", 32'(req_ready[0]), 32'd1);
        step;

        // a fresh transaction works after the reset
        txn(0, 32'h0220D0B3, 32'd100, 32'd7, -1, 1, 1'b1, 32'd14, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
